// File: rtl/fight_referee_pkg.sv
// fight_pkg: shared encodings for the fight match logic.
//   - player current_state codes (also used by the player module)
//   - hitFlag, round_state and winner encodings
//   - box field layout {x1,x2,y1,y2}, 10 bits per coordinate
//   - small helpers for box normalisation and saturating damage
package fight_pkg;

  localparam int COORD_W = 10;
  localparam int BOX_W   = 4 * COORD_W;

  // Field offsets inside a 40-bit box {x1,x2,y1,y2}
  localparam int X1_LSB = 3 * COORD_W;
  localparam int X2_LSB = 2 * COORD_W;
  localparam int Y1_LSB = 1 * COORD_W;
  localparam int Y2_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE           = 4'd0,
    S_MOVEFORWARDS   = 4'd1,
    S_MOVEBACKWARDS  = 4'd2,
    S_B_ATTACK_START = 4'd3,
    S_B_ATTACK_END   = 4'd4,
    S_B_ATTACK_PULL  = 4'd5,
    S_D_ATTACK_START = 4'd6,
    S_D_ATTACK_END   = 4'd7,
    S_D_ATTACK_PULL  = 4'd8,
    S_HITSTUN        = 4'd9,
    S_BLOCKSTUN      = 4'd10
  } player_state_e;

  typedef enum logic [1:0] {
    HIT_NONE  = 2'b00,
    HIT_BASIC = 2'b01,
    HIT_DIR   = 2'b10
  } hit_flag_e;

  typedef enum logic [1:0] {
    R_INTRO = 2'd0,
    R_FIGHT = 2'd1,
    R_KO    = 2'd2,
    R_OVER  = 2'd3
  } round_state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10,
    W_DRAW = 2'b11
  } winner_e;

  function automatic logic [COORD_W-1:0] coord_min(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] coord_max(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  // Health never wraps: a hit bigger than what is left just empties the bar.
  function automatic logic [2:0] health_sub(input logic [2:0] health,
                                            input logic [2:0] dmg);
    return (health > dmg) ? 3'(health - dmg) : 3'd0;
  endfunction

endpackage

// File: rtl/fight_referee_box_overlap.sv
// box_overlap: combinational normalise-and-compare of two boxes.
//   a_box   in  40  {x1,x2,y1,y2}; either corner order accepted
//   b_box   in  40  {x1,x2,y1,y2}; either corner order accepted
//   overlap out 1   boxes share at least one point (edges touching count)
module box_overlap
  import fight_pkg::*;
(
  input  logic [BOX_W-1:0] a_box,
  input  logic [BOX_W-1:0] b_box,
  output logic             overlap
);

  logic [COORD_W-1:0] a_xlo, a_xhi, a_ylo, a_yhi;
  logic [COORD_W-1:0] b_xlo, b_xhi, b_ylo, b_yhi;
  logic               x_ovl, y_ovl;

  // Sprites facing left hand us boxes with x1 > x2, so sort each axis first.
  assign a_xlo = coord_min(a_box[X1_LSB +: COORD_W], a_box[X2_LSB +: COORD_W]);
  assign a_xhi = coord_max(a_box[X1_LSB +: COORD_W], a_box[X2_LSB +: COORD_W]);
  assign a_ylo = coord_min(a_box[Y1_LSB +: COORD_W], a_box[Y2_LSB +: COORD_W]);
  assign a_yhi = coord_max(a_box[Y1_LSB +: COORD_W], a_box[Y2_LSB +: COORD_W]);
  assign b_xlo = coord_min(b_box[X1_LSB +: COORD_W], b_box[X2_LSB +: COORD_W]);
  assign b_xhi = coord_max(b_box[X1_LSB +: COORD_W], b_box[X2_LSB +: COORD_W]);
  assign b_ylo = coord_min(b_box[Y1_LSB +: COORD_W], b_box[Y2_LSB +: COORD_W]);
  assign b_yhi = coord_max(b_box[Y1_LSB +: COORD_W], b_box[Y2_LSB +: COORD_W]);

  assign x_ovl   = (a_xlo <= b_xhi) && (b_xlo <= a_xhi);
  assign y_ovl   = (a_ylo <= b_yhi) && (b_ylo <= a_yhi);
  assign overlap = x_ovl && y_ovl;

endmodule

// File: rtl/fight_referee.sv
// fight_referee: match controller between the two players and the top level.
// Resolves hits once per frame, tracks health and round wins, and sequences
// rounds R_INTRO -> R_FIGHT -> R_KO -> (R_INTRO | R_OVER).
//   clk                       frame clock, one tick per game frame
//   rst                       synchronous, active-low reset
//   start                     begins a new match (only honoured in R_OVER)
//   p1_state / p2_state       player current_state codes
//   p*_basic_box / p*_dir_box attack boxes {x1,x2,y1,y2}
//   p*_hurt_box               main hurtbox {x1,x2,y1,y2}
//   p1_hitFlag / p2_hitFlag   registered one-frame hit flag to the defender
//   p1_health / p2_health     remaining health
//   p1_wins / p2_wins         rounds won this match
//   round_state               current round phase
//   freeze                    high outside R_FIGHT
//   players_rst               one-frame pulse re-initialising the players
//   winner                    round/match result, valid in R_KO and R_OVER
// Optional: define FIGHT_TIMER_EN to add a per-round countdown (`timer`).
module fight_referee
  import fight_pkg::*;
#(
  parameter int unsigned MAX_HEALTH    = 7,
  parameter int unsigned DMG_BASIC     = 1,
  parameter int unsigned DMG_DIR       = 2,
  parameter int unsigned INTRO_FRAMES  = 90,
  parameter int unsigned KO_FRAMES     = 120,
  parameter int unsigned ROUNDS_TO_WIN = 2
`ifdef FIGHT_TIMER_EN
  ,
  parameter int unsigned ROUND_SECONDS  = 60,
  parameter int unsigned FRAMES_PER_SEC = 60
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       p1_state,
  input  logic [3:0]       p2_state,
  input  logic [BOX_W-1:0] p1_basic_box,
  input  logic [BOX_W-1:0] p2_basic_box,
  input  logic [BOX_W-1:0] p1_dir_box,
  input  logic [BOX_W-1:0] p2_dir_box,
  input  logic [BOX_W-1:0] p1_hurt_box,
  input  logic [BOX_W-1:0] p2_hurt_box,
  output logic [1:0]       p1_hitFlag,
  output logic [1:0]       p2_hitFlag,
  output logic [2:0]       p1_health,
  output logic [2:0]       p2_health,
  output logic [1:0]       p1_wins,
  output logic [1:0]       p2_wins,
  output logic [1:0]       round_state,
  output logic             freeze,
  output logic             players_rst,
  output logic [1:0]       winner
`ifdef FIGHT_TIMER_EN
  ,
  output logic [6:0]       timer
`endif
);

  localparam logic [2:0] HEALTH_FULL = 3'(MAX_HEALTH);
  localparam logic [2:0] DMG_B       = 3'(DMG_BASIC);
  localparam logic [2:0] DMG_D       = 3'(DMG_DIR);
  localparam logic [7:0] INTRO_LAST  = 8'(INTRO_FRAMES - 1);
  localparam logic [7:0] KO_LAST     = 8'(KO_FRAMES - 1);
  localparam logic [1:0] WINS_GOAL   = 2'(ROUNDS_TO_WIN);

  round_state_e round_q, round_d;
  winner_e      winner_q, winner_d;
  hit_flag_e    p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [2:0]   p1_health_q, p1_health_d, p2_health_q, p2_health_d;
  logic [1:0]   p1_wins_q, p1_wins_d, p2_wins_q, p2_wins_d;
  logic         p1_landed_q, p1_landed_d, p2_landed_q, p2_landed_d;
  logic         players_rst_q, players_rst_d;
`ifdef FIGHT_TIMER_EN
  localparam logic [6:0] TIMER_LOAD = 7'(ROUND_SECONDS);
  localparam logic [7:0] SEC_LAST   = 8'(FRAMES_PER_SEC - 1);
  logic [6:0]   timer_q, timer_d;
`endif

  // Round-end bookkeeping shared by KO and timeout paths.
  logic    end_round;
  winner_e end_winner;

  // ---------------------------------------------------------------------------
  // Hit detection
  // ---------------------------------------------------------------------------
  logic             p1_attacking, p2_attacking;
  logic             p1_is_dir, p2_is_dir;
  logic [BOX_W-1:0] p1_atk_box, p2_atk_box;
  logic             p1_ovl, p2_ovl;
  logic             p1_hits, p2_hits;

  assign p1_is_dir    = (p1_state == S_D_ATTACK_END);
  assign p2_is_dir    = (p2_state == S_D_ATTACK_END);
  assign p1_attacking = (p1_state == S_B_ATTACK_END) || p1_is_dir;
  assign p2_attacking = (p2_state == S_B_ATTACK_END) || p2_is_dir;
  assign p1_atk_box   = p1_is_dir ? p1_dir_box : p1_basic_box;
  assign p2_atk_box   = p2_is_dir ? p2_dir_box : p2_basic_box;

  box_overlap u_p1_vs_p2 (
    .a_box   (p1_atk_box),
    .b_box   (p2_hurt_box),
    .overlap (p1_ovl)
  );

  box_overlap u_p2_vs_p1 (
    .a_box   (p2_atk_box),
    .b_box   (p1_hurt_box),
    .overlap (p2_ovl)
  );

  // The landed latch masks the rest of the active window after one hit.
  assign p1_hits = (round_q == R_FIGHT) && p1_attacking && !p1_landed_q && p1_ovl;
  assign p2_hits = (round_q == R_FIGHT) && p2_attacking && !p2_landed_q && p2_ovl;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    round_d       = round_q;
    winner_d      = winner_q;
    cnt_d         = cnt_q;
    p1_health_d   = p1_health_q;
    p2_health_d   = p2_health_q;
    p1_wins_d     = p1_wins_q;
    p2_wins_d     = p2_wins_q;
    p1_hit_d      = HIT_NONE;
    p2_hit_d      = HIT_NONE;
    p1_landed_d   = p1_attacking ? p1_landed_q : 1'b0;
    p2_landed_d   = p2_attacking ? p2_landed_q : 1'b0;
    players_rst_d = 1'b0;
    end_round     = 1'b0;
    end_winner    = W_NONE;
`ifdef FIGHT_TIMER_EN
    timer_d       = timer_q;
`endif

    // Both attackers are resolved independently so trades land both ways.
    if (p1_hits) begin
      p1_landed_d = 1'b1;
      p2_hit_d    = p1_is_dir ? HIT_DIR : HIT_BASIC;
      if (p2_state != S_MOVEBACKWARDS)
        p2_health_d = health_sub(p2_health_q, p1_is_dir ? DMG_D : DMG_B);
    end
    if (p2_hits) begin
      p2_landed_d = 1'b1;
      p1_hit_d    = p2_is_dir ? HIT_DIR : HIT_BASIC;
      if (p1_state != S_MOVEBACKWARDS)
        p1_health_d = health_sub(p1_health_q, p2_is_dir ? DMG_D : DMG_B);
    end

    case (round_q)
      R_OVER: begin
        if (start) begin
          round_d       = R_INTRO;
          cnt_d         = 8'd0;
          winner_d      = W_NONE;
          p1_wins_d     = 2'd0;
          p2_wins_d     = 2'd0;
          p1_health_d   = HEALTH_FULL;
          p2_health_d   = HEALTH_FULL;
          players_rst_d = 1'b1;
`ifdef FIGHT_TIMER_EN
          timer_d       = TIMER_LOAD;
`endif
        end
      end

      R_INTRO: begin
        if (cnt_q == INTRO_LAST) begin
          round_d = R_FIGHT;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      R_FIGHT: begin
        // KO is judged on post-hit health so the round ends on the same
        // frame the finishing flag goes out.
        if (p1_health_d == 3'd0 || p2_health_d == 3'd0) begin
          end_round = 1'b1;
          if (p1_health_d == 3'd0 && p2_health_d == 3'd0) end_winner = W_DRAW;
          else if (p2_health_d == 3'd0)                   end_winner = W_P1;
          else                                            end_winner = W_P2;
        end
`ifdef FIGHT_TIMER_EN
        // In R_FIGHT the frame counter doubles as the sub-second divider.
        if (cnt_q == SEC_LAST) begin
          cnt_d = 8'd0;
          if (timer_q != 7'd0) timer_d = timer_q - 7'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (!end_round && timer_d == 7'd0) begin
          end_round = 1'b1;
          if (p1_health_d > p2_health_d)      end_winner = W_P1;
          else if (p2_health_d > p1_health_d) end_winner = W_P2;
          else                                end_winner = W_DRAW;
        end
`endif
        if (end_round) begin
          round_d  = R_KO;
          cnt_d    = 8'd0;
          winner_d = end_winner;
          if (end_winner == W_P1 && p1_wins_q != 2'd3) p1_wins_d = p1_wins_q + 2'd1;
          if (end_winner == W_P2 && p2_wins_q != 2'd3) p2_wins_d = p2_wins_q + 2'd1;
        end
      end

      R_KO: begin
        if (cnt_q == KO_LAST) begin
          cnt_d = 8'd0;
          if (p1_wins_q >= WINS_GOAL || p2_wins_q >= WINS_GOAL) begin
            round_d = R_OVER;
          end else begin
            round_d       = R_INTRO;
            winner_d      = W_NONE;
            p1_health_d   = HEALTH_FULL;
            p2_health_d   = HEALTH_FULL;
            players_rst_d = 1'b1;
`ifdef FIGHT_TIMER_EN
            timer_d       = TIMER_LOAD;
`endif
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: round_d = R_OVER;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      round_q       <= R_OVER;
      winner_q      <= W_NONE;
      cnt_q         <= 8'd0;
      p1_health_q   <= HEALTH_FULL;
      p2_health_q   <= HEALTH_FULL;
      p1_wins_q     <= 2'd0;
      p2_wins_q     <= 2'd0;
      p1_hit_q      <= HIT_NONE;
      p2_hit_q      <= HIT_NONE;
      p1_landed_q   <= 1'b0;
      p2_landed_q   <= 1'b0;
      players_rst_q <= 1'b0;
`ifdef FIGHT_TIMER_EN
      timer_q       <= 7'(ROUND_SECONDS);
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop loads from the values
      // that existed before this edge, independent of statement order.
      round_q       <= round_d;
      winner_q      <= winner_d;
      cnt_q         <= cnt_d;
      p1_health_q   <= p1_health_d;
      p2_health_q   <= p2_health_d;
      p1_wins_q     <= p1_wins_d;
      p2_wins_q     <= p2_wins_d;
      p1_hit_q      <= p1_hit_d;
      p2_hit_q      <= p2_hit_d;
      p1_landed_q   <= p1_landed_d;
      p2_landed_q   <= p2_landed_d;
      players_rst_q <= players_rst_d;
`ifdef FIGHT_TIMER_EN
      timer_q       <= timer_d;
`endif
    end
  end

  assign p1_hitFlag  = p1_hit_q;
  assign p2_hitFlag  = p2_hit_q;
  assign p1_health   = p1_health_q;
  assign p2_health   = p2_health_q;
  assign p1_wins     = p1_wins_q;
  assign p2_wins     = p2_wins_q;
  assign round_state = round_q;
  assign freeze      = (round_q != R_FIGHT);
  assign players_rst = players_rst_q;
  assign winner      = winner_q;
`ifdef FIGHT_TIMER_EN
  assign timer       = timer_q;
`endif

endmodule

// File: tb/tb_fight_referee.sv
// Directed bench for fight_referee (default build, no round timer).
module tb_fight_referee;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  p1_state, p2_state;
  logic [39:0] p1_basic_box, p2_basic_box, p1_dir_box, p2_dir_box;
  logic [39:0] p1_hurt_box, p2_hurt_box;
  logic [1:0]  p1_hitFlag, p2_hitFlag;
  logic [2:0]  p1_health, p2_health;
  logic [1:0]  p1_wins, p2_wins;
  logic [1:0]  round_state;
  logic        freeze, players_rst;
  logic [1:0]  winner;

  int checks   = 0;
  int failures = 0;

  fight_referee dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .p1_state     (p1_state),
    .p2_state     (p2_state),
    .p1_basic_box (p1_basic_box),
    .p2_basic_box (p2_basic_box),
    .p1_dir_box   (p1_dir_box),
    .p2_dir_box   (p2_dir_box),
    .p1_hurt_box  (p1_hurt_box),
    .p2_hurt_box  (p2_hurt_box),
    .p1_hitFlag   (p1_hitFlag),
    .p2_hitFlag   (p2_hitFlag),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .p1_wins      (p1_wins),
    .p2_wins      (p2_wins),
    .round_state  (round_state),
    .freeze       (freeze),
    .players_rst  (players_rst),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one frame; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_states(input logic [3:0] s1, input logic [3:0] s2);
    p1_state = s1;
    p2_state = s2;
  endtask

  function automatic logic [39:0] box(input int x1, input int x2, input int y1, input int y2);
    return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
  endfunction

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    set_states(4'd0, 4'd0);
    // P2 hurtbox x 100..140, y 0..50; P1 hurtbox given reversed: x 260..300, y 0..50
    p2_hurt_box  = box(100, 140, 0, 50);
    p1_hurt_box  = box(300, 260, 50, 0);
    p1_basic_box = box(90, 99, 10, 20);     // one pixel short of P2
    p1_dir_box   = box(145, 120, 40, 30);   // reversed corners, overlaps P2
    p2_basic_box = box(250, 260, 20, 30);   // touches P1 at x=260
    p2_dir_box   = box(280, 270, 60, 50);   // touches P1 at y=50

    // ---- 1: reset and match start --------------------------------------
    tick(); tick();
    check("rst_round", round_state, 3);
    check("rst_p1_health", p1_health, 7);
    check("rst_p2_health", p2_health, 7);
    check("rst_freeze", freeze, 1);
    check("rst_players_rst", players_rst, 0);
    check("rst_winner", winner, 0);
    check("rst_flags", {p1_hitFlag, p2_hitFlag}, 0);
    check("rst_wins", {p1_wins, p2_wins}, 0);
    rst = 1'b1;
    tick();
    check("idle_over", round_state, 3);
    start = 1'b1;
    tick();
    check("start_prst", players_rst, 1);
    check("start_intro", round_state, 0);
    start = 1'b0;
    tick();
    check("prst_one_cycle", players_rst, 0);
    repeat (88) tick();
    check("intro_last", round_state, 0);
    check("intro_freeze", freeze, 1);
    tick();
    check("fight_round", round_state, 1);
    check("fight_freeze", freeze, 0);

    // ---- 2: basic hit, inclusive edge, one hit per swing ---------------
    set_states(4'd4, 4'd0);
    tick();
    check("edge_miss_flag", p2_hitFlag, 0);
    p1_basic_box = box(90, 100, 10, 20);    // now touches x=100
    tick();
    check("basic_flag", p2_hitFlag, 1);
    check("basic_health", p2_health, 6);
    check("basic_no_self", p1_hitFlag, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("basic_hold_flag", p2_hitFlag, 0);
    end
    check("basic_hold_health", p2_health, 6);
    set_states(4'd0, 4'd0);
    tick();

    // ---- 3: directional hit, blocked then unblocked --------------------
    set_states(4'd7, 4'd2);
    tick();
    check("block_flag", p2_hitFlag, 2);
    check("block_health", p2_health, 6);
    set_states(4'd0, 4'd0);
    tick();
    set_states(4'd7, 4'd0);
    tick();
    check("dir_flag", p2_hitFlag, 2);
    check("dir_health", p2_health, 4);
    set_states(4'd0, 4'd0);
    tick();

    // Bring P2 to 1 and P1 to 1
    set_states(4'd4, 4'd0); tick(); check("p2_to3", p2_health, 3);
    set_states(4'd0, 4'd0); tick();
    set_states(4'd7, 4'd0); tick(); check("p2_to1", p2_health, 1);
    set_states(4'd0, 4'd0); tick();
    for (int i = 0; i < 3; i++) begin
      set_states(4'd0, 4'd7);
      tick();
      check("p2_dir_flag", p1_hitFlag, 2);
      check("p1_health_drop", p1_health, 5 - 2 * i);
      set_states(4'd0, 4'd0);
      tick();
    end

    // ---- 4: trade to a double KO -----------------------------------------
    set_states(4'd4, 4'd4);
    tick();
    check("trade_flags", {p1_hitFlag, p2_hitFlag}, 4'b0101);
    check("trade_health", {p1_health, p2_health}, 0);
    check("trade_ko", round_state, 2);
    check("trade_draw", winner, 3);
    check("trade_wins", {p1_wins, p2_wins}, 0);
    set_states(4'd0, 4'd0);
    repeat (118) tick();
    start = 1'b1;                            // ignored outside R_OVER
    tick();
    start = 1'b0;
    check("ko_hold", round_state, 2);
    tick();
    check("ko_to_intro", round_state, 0);
    check("ko_restore", {p1_health, p2_health}, 6'o77);
    check("ko_prst", players_rst, 1);
    check("ko_winner_clr", winner, 0);

    // ---- 5: P1 takes two rounds ------------------------------------------
    for (int r = 1; r <= 2; r++) begin
      repeat (90) tick();
      check("round_fight", round_state, 1);
      for (int h = 0; h < 4; h++) begin
        set_states(4'd7, 4'd0);
        tick();
        check("ko_swing_health", p2_health, (h == 3) ? 0 : 5 - 2 * h);
        set_states(4'd0, 4'd0);
        if (h != 3) tick();
      end
      check("p2_ko_round", round_state, 2);
      check("p2_ko_winner", winner, 1);
      check("p1_wins_count", p1_wins, r);
      if (r == 1) begin
        repeat (119) tick();
        check("ko1_hold", round_state, 2);
        tick();
        check("ko1_intro", round_state, 0);
      end
    end
    repeat (120) tick();
    check("match_over", round_state, 3);
    check("match_winner", winner, 1);
    check("match_freeze", freeze, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_wins", {p1_wins, p2_wins}, 0);
    check("restart_intro", round_state, 0);
    check("restart_winner", winner, 0);

    // ---- 6: reset overrides a hit in R_FIGHT -----------------------------
    repeat (90) tick();
    check("rst_fight", round_state, 1);
    set_states(4'd4, 4'd0);
    rst = 1'b0;
    tick();
    check("rst_mid_flags", {p1_hitFlag, p2_hitFlag}, 0);
    check("rst_mid_round", round_state, 3);
    check("rst_mid_health", p2_health, 7);
    rst = 1'b1;
    set_states(4'd0, 4'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
